// File: rtl/rv_mdu_iter.sv
// Iterative RV M-extension multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Optional macro RV_MDU_FAST_MUL_EN: multiplies use a single-cycle 2*XLEN multiplier instead of iterating.
`timescale 1ns/1ps
module rv_mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] v);
    return ~v + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  state_t          state_r;
  logic [2:0]      op_r;
  logic            neg_r;
  logic [XLEN-1:0] opb_r;
  logic [PW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] res_r;
  logic [XLEN-1:0] result_r;
  logic            busy_r;
  logic            done_r;

  logic            a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_s, special_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s, spec_res_s;
  logic [XLEN:0]   mul_sum_s, shl_s, diff_s;
  logic            ge_s;
  logic [PW-1:0]   step_next_s, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fix_s;
`ifdef RV_MDU_FAST_MUL_EN
  logic [PW-1:0]   fast_prod_s;
  assign fast_prod_s = PW'(mag_a_s) * PW'(mag_b_s);
`endif

  // Capture-time decode: operand signs, magnitudes, sign-fix flag and early-out results
  always_comb begin
    a_sgn_s    = 1'b0;
    b_sgn_s    = 1'b0;
    neg_s      = 1'b0;
    special_s  = 1'b0;
    spec_res_s = ZERO;
    case (op)
      3'b001:         begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      3'b010:         begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
      3'b100, 3'b110: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      default:        begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
    endcase
    a_neg_s = a_sgn_s & a[XLEN-1];
    b_neg_s = b_sgn_s & b[XLEN-1];
    if (a_neg_s) mag_a_s = neg_x(a); else mag_a_s = a;
    if (b_neg_s) mag_b_s = neg_x(b); else mag_b_s = b;
    if (op[2]) begin
      // remainder follows the dividend sign, quotient the sign product
      if (op[1]) neg_s = a_neg_s; else neg_s = a_neg_s ^ b_neg_s;
      if (b == ZERO) begin
        special_s = 1'b1;
        if (op[1]) spec_res_s = a; else spec_res_s = ONES;
      end else if (!op[0] && (a == MIN_INT) && (b == ONES)) begin
        special_s = 1'b1;
        if (op[1]) spec_res_s = ZERO; else spec_res_s = MIN_INT;
      end else begin
        special_s  = 1'b0;
        spec_res_s = ZERO;
      end
    end else begin
      neg_s = a_neg_s ^ b_neg_s;
      if ((a == ZERO) || (b == ZERO)) special_s = 1'b1; else special_s = 1'b0;
    end
  end

  // One radix-2 step: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum_s = {1'b0, acc_r[PW-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    shl_s     = {acc_r[PW-1:XLEN], acc_r[XLEN-1]};
    ge_s      = (shl_s >= {1'b0, opb_r});
    diff_s    = shl_s - {1'b0, opb_r};
    if (op_r[2]) begin
      if (ge_s) step_next_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      else      step_next_s = {shl_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    end else begin
      step_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Sign correction and result-half selection
  always_comb begin
    if (neg_r) begin
      prod_s = neg_p(acc_r);
      quo_s  = neg_x(acc_r[XLEN-1:0]);
      rem_s  = neg_x(acc_r[PW-1:XLEN]);
    end else begin
      prod_s = acc_r;
      quo_s  = acc_r[XLEN-1:0];
      rem_s  = acc_r[PW-1:XLEN];
    end
    case (op_r)
      3'b000:                 fix_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_s = prod_s[PW-1:XLEN];
      3'b100, 3'b101:         fix_s = quo_s;
      3'b110, 3'b111:         fix_s = rem_s;
      default:                fix_s = ZERO;
    endcase
  end

  // Control FSM with registered busy/done/result; kill overrides every transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      op_r     <= 3'b000;
      neg_r    <= 1'b0;
      opb_r    <= ZERO;
      acc_r    <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      res_r    <= ZERO;
      result_r <= ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (kill) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              op_r  <= op;
              neg_r <= neg_s;
              opb_r <= mag_b_s;
              res_r <= spec_res_s;
              if (special_s) begin
                state_r <= DONE;
                busy_r  <= 1'b0;
`ifdef RV_MDU_FAST_MUL_EN
              end else if (!op[2]) begin
                acc_r   <= fast_prod_s;
                state_r <= FIX;
                busy_r  <= 1'b1;
`endif
              end else begin
                acc_r   <= {ZERO, mag_a_s};
                cnt_r   <= CNT_MAX;
                state_r <= CALC;
                busy_r  <= 1'b1;
              end
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
          CALC: begin
            acc_r <= step_next_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) state_r <= FIX;
            else                  state_r <= CALC;
            busy_r <= 1'b1;
          end
          FIX: begin
            res_r   <= fix_s;
            state_r <= DONE;
            busy_r  <= 1'b0;
          end
          DONE: begin
            result_r <= res_r;
            done_r   <= 1'b1;
            state_r  <= IDLE;
            busy_r   <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
endmodule

// File: tb/tb_rv_mdu_iter.sv
// Directed self-checking bench for rv_mdu_iter at XLEN=32: results, latency, specials and handshake abuse.
`timescale 1ns/1ps
module tb_rv_mdu_iter;
  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        kill  = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy, done;
  logic [31:0] result;
  int checks = 0;
  int errors = 0;

`ifdef RV_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT  = 34;
  localparam int SPEC_LAT = 1;

  rv_mdu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Issue one request and report the edge on which done appeared, the result, and the pulse width
  task automatic drive_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int seen, output logic [31:0] res, output logic still_high);
    seen = 0;
    res  = 32'd0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    for (int i = 1; i <= 60 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (done) begin seen = i; res = result; end
    end
    @(posedge clk); #1;
    still_high = done;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, result} !== 34'd0) begin
      errors++; $display("FAIL reset_hold: busy=%b done=%b result=%h, required 0/0/0", busy, done, result);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, result} !== 34'd0) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b result=%h, required 0/0/0", busy, done, result);
    end
  endtask

  task automatic test_mul;
    logic [2:0]  ops  [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
    logic [31:0] va   [4] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] vb   [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF};
    logic [31:0] vexp [4] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
    int seen; logic [31:0] res; logic hi;
    for (int k = 0; k < 4; k++) begin
      drive_op(ops[k], va[k], vb[k], seen, res, hi);
      checks++;
      if (seen !== MUL_LAT) begin
        errors++; $display("FAIL mul%0d_latency: got %0d, required %0d", k, seen, MUL_LAT);
      end
      checks++;
      if (res !== vexp[k]) begin
        errors++; $display("FAIL mul%0d_result: got %h, required %h", k, res, vexp[k]);
      end
      checks++;
      if (hi !== 1'b0) begin
        errors++; $display("FAIL mul%0d_pulse: done=%b one cycle later, required 0", k, hi);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] va   [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] vb   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] vexp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    int seen; logic [31:0] res; logic hi;
    for (int k = 0; k < 4; k++) begin
      drive_op(ops[k], va[k], vb[k], seen, res, hi);
      checks++;
      if (seen !== DIV_LAT) begin
        errors++; $display("FAIL div%0d_latency: got %0d, required %0d", k, seen, DIV_LAT);
      end
      checks++;
      if (res !== vexp[k]) begin
        errors++; $display("FAIL div%0d_result: got %h, required %h", k, res, vexp[k]);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops  [5] = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b000};
    logic [31:0] va   [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd0};
    logic [31:0] vb   [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
    logic [31:0] vexp [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd0};
    int seen; logic [31:0] res; logic hi;
    for (int k = 0; k < 5; k++) begin
      drive_op(ops[k], va[k], vb[k], seen, res, hi);
      checks++;
      if (seen !== SPEC_LAT) begin
        errors++; $display("FAIL spec%0d_latency: got %0d, required %0d", k, seen, SPEC_LAT);
      end
      checks++;
      if (res !== vexp[k]) begin
        errors++; $display("FAIL spec%0d_result: got %h, required %h", k, res, vexp[k]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int seen; int extra; logic [31:0] res;
    seen = 0; extra = 0; res = 32'd0;
    @(negedge clk);
    op = 3'b101; a = 32'd1000; b = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 60 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3; end
      else start = 1'b0;
      if (done) begin seen = i; res = result; end
    end
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++;
    if (seen !== DIV_LAT) begin
      errors++; $display("FAIL restart_latency: got %0d, required %0d", seen, DIV_LAT);
    end
    checks++;
    if (res !== 32'd100) begin
      errors++; $display("FAIL restart_result: got %h, required %h", res, 32'd100);
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL restart_no_second_op: %0d active cycles, required 0", extra);
    end
  endtask

  task automatic test_kill;
    int pulses; logic busy_mid;
    pulses = 0;
    @(negedge clk);
    op = 3'b101; a = 32'd50; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    busy_mid = busy;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if (busy_mid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL kill_busy: before=%b after=%b, required 1 then 0", busy_mid, busy);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL kill_no_done: %0d done pulses, required 0", pulses);
    end
    checks++;
    if (result !== 32'd100) begin
      errors++; $display("FAIL kill_result_held: got %h, required %h", result, 32'd100);
    end
  endtask

  task automatic test_mid_reset;
    int seen; int pulses; logic [31:0] res; logic hi;
    pulses = 0;
    @(negedge clk);
    op = 3'b101; a = 32'd77; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, result} !== 34'd0) begin
      errors++; $display("FAIL midreset_clear: busy=%b done=%b result=%h, required 0/0/0", busy, done, result);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL midreset_no_done: %0d done pulses, required 0", pulses);
    end
    drive_op(3'b000, 32'd3, 32'd4, seen, res, hi);
    checks++;
    if (seen !== MUL_LAT || res !== 32'd12) begin
      errors++; $display("FAIL midreset_fresh_mul: latency %0d result %h, required %0d and %h", seen, res, MUL_LAT, 32'd12);
    end
  endtask

  task automatic test_kill_idle;
    int active;
    active = 0;
    @(negedge clk);
    op = 3'b101; a = 32'd9; b = 32'd3; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy || done) active++;
      @(posedge clk); #1;
    end
    checks++;
    if (active !== 0) begin
      errors++; $display("FAIL kill_idle_dropped: %0d active cycles, required 0", active);
    end
    checks++;
    if (result !== 32'd12) begin
      errors++; $display("FAIL kill_idle_result: got %h, required %h", result, 32'd12);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_ignored();
    test_kill();
    test_mid_reset();
    test_kill_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
